stepper_seq_ctrl: RTL

- Parametrised 4-phase unipolar stepper sequencer, successor to the fixed-rate, fixed-2048-step rotator.
- Accepts a move command: step count, direction, drive mode and step period. Issues coil patterns at the programmed rate, tracks absolute position, and reports busy/done.
- Sits between the control logic (buttons/UART command decoder) and the motor driver pins.
- Supports wave, full-step and half-step drive, abort, and an idle hold/release option.

---
 rtl/stepper_pkg.sv | 34 +++
 rtl/step_rate_gen.sv | 34 +++
 rtl/stepper_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared encodings and phase table for the stepper sequencer
package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ph = {A, B, /A, /B}; even entries single-coil, odd entries two-coil
  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    logic [3:0] ph;
    case (idx)
      3'd0:    ph = 4'b1000;
      3'd1:    ph = 4'b1100;
      3'd2:    ph = 4'b0100;
      3'd3:    ph = 4'b0110;
      3'd4:    ph = 4'b0010;
      3'd5:    ph = 4'b0011;
      3'd6:    ph = 4'b0001;
      default: ph = 4'b1001;
    endcase
    return ph;
  endfunction

  // Driver header carries the pattern twice, the second copy bit-reversed
  function automatic logic [7:0] drive_word(input logic [3:0] ph);
    return {ph, ph[0], ph[1], ph[2], ph[3]};
  endfunction

endpackage

// File: rtl/step_rate_gen.sv
// rtl/step_rate_gen.sv - programmable step prescaler; ticks on the first enabled cycle, then every period cycles
module step_rate_gen
  import stepper_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per_q;

  assign tick = enable && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      per_q <= PER_ONE;
    end else if (load) begin
      cnt   <= '0;
      per_q <= (period == '0) ? PER_ONE : period;
    end else if (enable) begin
      cnt   <= (cnt == per_q - PER_ONE) ? '0 : cnt + PER_ONE;
    end
  end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// rtl/stepper_seq_ctrl.sv - 4-phase unipolar stepper move sequencer with position tracking
module stepper_seq_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PER_W = 16,
  parameter int POS_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] steps,
  input  logic [PER_W-1:0] period,
  input  logic             hold_en,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position,
  output logic [7:0]       motor_data
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       idx;
  logic [2:0]       snap_idx;
  logic [2:0]       step_idx;
  logic [2:0]       stride;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] remaining;
  logic             stepped;
  logic             tick;
  logic             go;
  logic             go_run;
  logic             go_zero;
  logic             step_fire;
  logic             last_step;
  logic             done_nxt;
  logic [7:0]       motor_nxt;

  assign go        = (state == ST_IDLE) && start && !abort;
  assign go_run    = go && (steps != '0);
  assign go_zero   = go && (steps == '0);
  assign step_fire = (state == ST_RUN) && tick && !abort;
  assign last_step = step_fire && (remaining == CNT_ONE);

  // Wave lives on even (single-coil) entries, full on odd (two-coil) entries
  always_comb begin
    snap_idx = idx;
    if (mode == MODE_WAVE)      snap_idx = {idx[2:1], 1'b0};
    else if (mode == MODE_FULL) snap_idx = {idx[2:1], 1'b1};
  end

  assign stride   = (mode_q == MODE_WAVE || mode_q == MODE_FULL) ? 3'd2 : 3'd1;
  assign step_idx = dir_q ? idx + stride : idx - stride;

  step_rate_gen #(
    .PER_W (PER_W)
  ) u_rate (
    .clk    (clk),
    .reset  (reset),
    .load   (go_run),
    .enable (state == ST_RUN),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go_run) state_nxt = ST_RUN;
      ST_RUN:  if (abort || last_step) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_RUN);
    done_nxt  = 1'b0;
    motor_nxt = motor_data;
    case (state)
      ST_IDLE: begin
        done_nxt = go_zero;
        if (go_run)                motor_nxt = drive_word(phase_of(snap_idx));
        else if (hold_en && stepped) motor_nxt = drive_word(phase_of(idx));
        else                       motor_nxt = 8'h00;
      end
      ST_RUN: begin
        done_nxt = last_step;
        if (step_fire) motor_nxt = drive_word(phase_of(step_idx));
      end
      default: motor_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= 3'd0;
      dir_q      <= 1'b0;
      mode_q     <= MODE_WAVE;
      remaining  <= '0;
      position   <= '0;
      stepped    <= 1'b0;
      done       <= 1'b0;
      motor_data <= 8'h00;
    end else begin
      done       <= done_nxt;
      motor_data <= motor_nxt;
      if (go) begin
        dir_q     <= dir;
        mode_q    <= mode;
        remaining <= steps;
      end
      if (go_run) idx <= snap_idx;
      if (step_fire) begin
        idx       <= step_idx;
        position  <= dir_q ? position + POS_ONE : position - POS_ONE;
        remaining <= remaining - CNT_ONE;
        stepped   <= 1'b1;
      end
    end
  end

endmodule
